// File: rtl/sdr_wb_protocol_monitor.sv
// Passive protocol monitor for the SDRAM controller top level: checks SDRAM command timing,
// init sequencing, CAS programming and Wishbone handshakes, reporting via sticky flags.
module sdr_wb_protocol_monitor #(
    parameter int unsigned N_CS     = 1,
    parameter int unsigned SDR_AW   = 13,
    parameter int unsigned TRP_CYC  = 2,
    parameter int unsigned TRFC_CYC = 6,
    parameter int unsigned INIT_CYC = 10000,
    parameter int unsigned ACK_TMO  = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_ack_o,
    input  logic [N_CS-1:0]   sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [SDR_AW-1:0] sdr_addr,
    input  logic              sdr_init_done,
    input  logic [2:0]        cfg_sdr_cas,
    input  logic              clr_i,
    output logic [7:0]        err_flags_o,
    output logic              err_pulse_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [2:0]        first_err_o,
    output logic              first_vld_o,
    output logic [1:0]        init_state_o
);

    localparam int unsigned TMR_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned INIT_W  = $clog2(INIT_CYC + 1);
    localparam int unsigned WAIT_W  = $clog2(ACK_TMO + 1);

    localparam logic [1:0] StWait     = 2'd0;
    localparam logic [1:0] StDoneWait = 2'd1;
    localparam logic [1:0] StRun      = 2'd2;

    logic [2:0]        cmd;
    logic [TMR_W-1:0]  tmr_q [N_CS];
    logic [TMR_W-1:0]  tmr_d [N_CS];
    logic [N_CS-1:0]   tmr_ref_q, tmr_ref_d;
    logic [1:0]        state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0] ack_wait_q, ack_wait_d;
    logic              pend_q, pend_d;
    logic [7:0]        viol;
    logic              any_viol;
    logic [2:0]        viol_idx;
    logic              any_nonnop, any_mrs;
    logic              wb_req, wb_stall;
    logic [7:0]        flags_q;
    logic              pulse_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        first_q;
    logic              first_vld_q;
    logic              unused_addr;

    assign cmd         = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign wb_req      = wb_cyc_i & wb_stb_i;
    assign wb_stall    = wb_req & ~wb_ack_o;
    assign unused_addr = ^sdr_addr;

    always_comb begin
        viol       = '0;
        any_nonnop = 1'b0;
        any_mrs    = 1'b0;
        tmr_ref_d  = tmr_ref_q;
        for (int i = 0; i < N_CS; i++) begin
            tmr_d[i] = (tmr_q[i] != '0) ? tmr_q[i] - 1'b1 : tmr_q[i];
            if (!sdr_cs_n[i] && cmd != 3'b111) begin
                any_nonnop = 1'b1;
                // Timer source decides which flag a premature command raises
                if (tmr_q[i] != '0) begin
                    if (tmr_ref_q[i]) viol[0] = 1'b1;
                    else              viol[1] = 1'b1;
                end
                if (cmd == 3'b010) begin
                    tmr_d[i]     = TMR_W'(TRP_CYC);
                    tmr_ref_d[i] = 1'b0;
                end else if (cmd == 3'b001) begin
                    tmr_d[i]     = TMR_W'(TRFC_CYC);
                    tmr_ref_d[i] = 1'b1;
                end else if (cmd == 3'b000) begin
                    any_mrs = 1'b1;
                end
            end
        end

        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            StWait: begin
                if (any_nonnop || sdr_init_done) viol[2] = 1'b1;
                if (init_cnt_q == INIT_W'(INIT_CYC - 1)) begin
                    state_d    = StDoneWait;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StDoneWait: if (sdr_init_done) state_d = StRun;
            StRun: begin
                if (!sdr_init_done) begin
                    state_d    = StWait;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = StWait;
                init_cnt_d = '0;
            end
        endcase

        viol[3] = any_mrs && (sdr_addr[6:4] != cfg_sdr_cas);
        viol[4] = wb_ack_o & ~wb_req;
        viol[5] = wb_stb_i & ~wb_cyc_i;
        // Counter parks at ACK_TMO so a long stall reports only once
        viol[6] = wb_stall && (ack_wait_q == WAIT_W'(ACK_TMO - 1));
        viol[7] = pend_q & wb_cyc_i & ~wb_stb_i;

        if (!wb_stall)                          ack_wait_d = '0;
        else if (ack_wait_q != WAIT_W'(ACK_TMO)) ack_wait_d = ack_wait_q + 1'b1;
        else                                    ack_wait_d = ack_wait_q;
        pend_d = wb_stall;

        any_viol = |viol;
        viol_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (viol[i]) viol_idx = 3'(i);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < N_CS; i++) tmr_q[i] <= '0;
            tmr_ref_q  <= '0;
            state_q    <= StWait;
            init_cnt_q <= '0;
            ack_wait_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CS; i++) tmr_q[i] <= tmr_d[i];
            tmr_ref_q  <= tmr_ref_d;
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ack_wait_q <= ack_wait_d;
            pend_q     <= pend_d;
        end
    end

    // A violation in the same cycle as clr_i survives the clear
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            flags_q     <= '0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
            first_q     <= '0;
            first_vld_q <= 1'b0;
        end else begin
            pulse_q <= any_viol;
            if (clr_i) begin
                flags_q     <= viol;
                cnt_q       <= any_viol ? CNT_W'(1) : '0;
                first_q     <= any_viol ? viol_idx : 3'd0;
                first_vld_q <= any_viol;
            end else begin
                flags_q <= flags_q | viol;
                if (any_viol && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                if (any_viol && !first_vld_q) begin
                    first_q     <= viol_idx;
                    first_vld_q <= 1'b1;
                end
            end
        end
    end

    assign err_flags_o  = flags_q;
    assign err_pulse_o  = pulse_q;
    assign err_cnt_o    = cnt_q;
    assign first_err_o  = first_q;
    assign first_vld_o  = first_vld_q;
    assign init_state_o = state_q;

endmodule

// File: doc/sdr_wb_protocol_monitor.md
Name: sdr_wb_protocol_monitor

Overview:
- Synthesizable, parametrised protocol monitor for the SDRAM controller top level.
- Passively samples the Wishbone slave port and the SDRAM command bus on every rising clock edge.
- Checks SDRAM timing (per chip select), the init sequence, mode-register CAS programming and Wishbone handshake rules.
- Reports violations through sticky flags, a saturating error counter and a first-error capture, so checking works in emulation/FPGA as well as simulation.

Parameters:
- N_CS, 1, number of SDRAM chip selects tracked independently.
- SDR_AW, 13, SDRAM address bus width (>=7).
- TRP_CYC, 2, minimum idle cycles after PRECHARGE before the next non-NOP command on the same CS.
- TRFC_CYC, 6, minimum idle cycles after REFRESH before the next non-NOP command on the same CS.
- INIT_CYC, 10000, minimum cycles after reset release before any non-NOP command or sdr_init_done.
- ACK_TMO, 64, maximum cycles cyc&stb may stay high without ack.
- CNT_W, 16, error counter width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- wb_cyc_i  in  1  monitored Wishbone cycle.
- wb_stb_i  in  1  monitored Wishbone strobe.
- wb_ack_o  in  1  monitored slave acknowledge (input to this block).
- sdr_cs_n  in  N_CS  monitored chip selects, active low.
- sdr_ras_n  in  1  monitored RAS#.
- sdr_cas_n  in  1  monitored CAS#.
- sdr_we_n  in  1  monitored WE#.
- sdr_addr  in  SDR_AW  monitored SDRAM address.
- sdr_init_done  in  1  controller init-complete indication.
- cfg_sdr_cas  in  3  programmed CAS latency.
- clr_i  in  1  synchronous clear of flags, counter and capture.
- err_flags_o  out  8  sticky violation flags.
- err_pulse_o  out  1  one-cycle pulse on any new violation.
- err_cnt_o  out  CNT_W  saturating count of violating cycles.
- first_err_o  out  3  index of the lowest flag set in the first violating cycle.
- first_vld_o  out  1  first_err_o valid.
- init_state_o  out  2  0 WAIT, 1 DONE_WAIT, 2 RUN.

Behaviour:
- Reset: all outputs 0, all timers 0, FSM in WAIT with init counter 0.
- Command decode, only for a CS bit that is low:
  - NOP = ras/cas/we = 1/1/1
  - PRECHARGE = 0/1/0
  - REFRESH = 0/0/1
  - MRS = 0/0/0
  - All other combinations are "other non-NOP".
  - All CS high = deselect, treated as NOP.
- Per-CS timers:
  - PRECHARGE loads that CS's timer with TRP_CYC; REFRESH loads it with TRFC_CYC.
  - The timer decrements each cycle to 0.
  - Any non-NOP command on that CS while its timer is nonzero: bit0 if the timer was loaded by REFRESH, bit1 if by PRECHARGE. The violating command still reloads the timer.
- Init FSM:
  - WAIT: count to INIT_CYC, then go to DONE_WAIT. During WAIT, a non-NOP command on any CS, or sdr_init_done=1, sets bit2.
  - DONE_WAIT: go to RUN when sdr_init_done=1.
  - RUN: sdr_init_done falling returns to WAIT and clears the init counter.
- bit3: MRS with sdr_addr[6:4] != cfg_sdr_cas (any state).
- bit4: wb_ack_o=1 without wb_cyc_i&wb_stb_i.
- bit5: wb_stb_i=1 with wb_cyc_i=0.
- bit6: cyc&stb high, ack low, for ACK_TMO consecutive cycles.
  - The wait counter clears on ack or on cyc/stb low.
  - The flag fires once per stalled transfer.
- bit7: stb dropped while cyc stays high, when the previous cycle had cyc&stb=1 and ack=0.
- Timing of results:
  - Violations sampled at edge N appear in err_flags_o / err_pulse_o after edge N (1-cycle latency).
  - err_cnt_o increments by 1 per violating cycle, regardless of how many bits are set, and saturates at all-ones.
  - first_err_o / first_vld_o are written only while first_vld_o=0.
- clr_i clears flags, counter and capture. If a violation occurs in the same cycle, the new violation wins: flags are set, count = 1, capture loaded. clr_i does not affect timers or the FSM.
- Reset asserted mid-operation clears everything immediately (asynchronous).

Test Plan:
- REFRESH on CS0, NOP x3, ACTIVE (0/1/1) -> err_flags_o=0x01, err_pulse_o one cycle, first_err_o=0, err_cnt_o=1. Same sequence with 6 NOPs -> no flag.
- PRECHARGE on CS1, ACTIVE on CS0 next cycle (N_CS=2) -> no flag. PRECHARGE on CS1, ACTIVE on CS1 after 1 NOP -> bit1.
- Reset release, MRS at cycle 500 -> bit2, init_state_o=0. No command until cycle 10000, sdr_init_done=1 at 10005 -> init_state_o 0->1->2, no flag.
- cfg_sdr_cas=3, MRS with sdr_addr[6:4]=2 -> bit3. With sdr_addr[6:4]=3 -> none.
- cyc=stb=1, ack held 0 for 64 cycles -> bit6 exactly once. stb=1 with cyc=0 -> bit5. ack with stb=0 -> bit4. Both bit4 and bit5 in the same cycle -> err_cnt_o +1, first_err_o=4.
- Flags set, then clr_i together with a new bit7 violation -> err_flags_o=0x80, err_cnt_o=1, first_err_o=7. CNT_W=2 with 5 violating cycles -> err_cnt_o=3.
